// File: rtl/fetch_pkg.sv
// Shared widths, buffer entry type and counter sizing for the fetch stream.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 6;
  localparam int FETCH_DATA_W = 32;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] addr;
    logic [FETCH_DATA_W-1:0] data;
  } fetch_entry_t;

  // Occupancy counters must be able to hold the value DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous response buffer: push/pop/flush, occupancy count and a registered head.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = 4,
  parameter int  CW      = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_entry,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) assert (!(push && count == CW'(DEPTH)));
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stream.sv
// Sequential word-fetch engine: credit-limited reads into a small FIFO,
// with redirect that flushes the buffer and squashes reads still in flight.
module fetch_stream
  import fetch_pkg::*;
#(
  parameter  int                    ADDR_WIDTH = FETCH_ADDR_W,
  parameter  int                    DATA_SIZE  = FETCH_DATA_W / 8,
  parameter  int                    FIFO_DEPTH = 4,
  parameter  logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  localparam int                    DATA_WIDTH = DATA_SIZE * 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  input  logic                  ram_rd_valid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr
);

  localparam int CW = cnt_width(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] resp_pc;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         drop_cnt;
  logic [CW-1:0]         count;
  logic [CW:0]           credit_used;
  logic                  push;
  logic                  pop;
  logic                  resp_drop;
  entry_t                push_entry;
  entry_t                head;

  // Reads in flight reserve a FIFO slot, so a landing response never finds it full.
  assign credit_used = {1'b0, inflight} + {1'b0, count};
  assign ram_rd_en   = fetch_en & ~redirect_valid & ~rst &
                       (credit_used < (CW+1)'(FIFO_DEPTH));
  assign ram_rd_addr = pc;

  assign resp_drop  = ram_rd_valid & (drop_cnt != '0);
  assign push       = ram_rd_valid & ~rst & ~redirect_valid & (drop_cnt == '0);
  assign pop        = out_valid & out_ready & ~redirect_valid;
  assign push_entry = '{addr: resp_pc, data: ram_rd_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_ADDR;
      resp_pc  <= RESET_ADDR;
      inflight <= '0;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_addr;
      resp_pc  <= redirect_addr;
      drop_cnt <= drop_cnt + inflight - CW'(ram_rd_valid);
      inflight <= '0;
    end else begin
      if (ram_rd_en) pc       <= pc + 1'b1;
      if (push)      resp_pc  <= resp_pc + 1'b1;
      if (resp_drop) drop_cnt <= drop_cnt - 1'b1;
      inflight <= inflight + CW'(ram_rd_en) - CW'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert ({1'b0, inflight} + {1'b0, drop_cnt} <= (CW+1)'(FIFO_DEPTH));
  end

  fetch_fifo #(
    .entry_t (entry_t),
    .DEPTH   (FIFO_DEPTH),
    .CW      (CW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  assign out_valid = (count != '0);
  assign out_data  = head.data;
  assign out_addr  = head.addr;

endmodule

// File: tb/tb_fetch_stream.sv
// Bench for fetch_stream: fixed-latency RAM stand-in, directed scenarios, then random traffic
// checked against an expected-address stream model.
`timescale 1ns/1ps
module tb_fetch_stream;

  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam logic [AW-1:0] RESET_ADDR = '0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_en = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic          out_ready = 1'b0;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic          ram_rd_valid;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;

  int vecs = 0;
  int errs = 0;

  fetch_stream dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .ram_rd_en      (ram_rd_en),
    .ram_rd_addr    (ram_rd_addr),
    .ram_rd_data    (ram_rd_data),
    .ram_rd_valid   (ram_rd_valid),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_addr       (out_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    w = {{(DW-AW){1'b0}}, a} * 32'h1111_1111;
    return w;
  endfunction

  // RAM stand-in: every read answers exactly LAT cycles later, in order.
  logic [LAT-1:0] pipe_v = '0;
  logic [AW-1:0]  pipe_a [LAT];
  always @(posedge clk) begin
    pipe_v    <= {pipe_v[LAT-2:0], ram_rd_en};
    pipe_a[0] <= ram_rd_addr;
    for (int i = 1; i < LAT; i++) pipe_a[i] <= pipe_a[i-1];
  end
  assign ram_rd_valid = pipe_v[LAT-1];
  assign ram_rd_data  = word_of(pipe_a[LAT-1]);

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic fe, input logic rdy,
                                input logic rv, input logic [AW-1:0] ra, input int cycles);
    rst            = r;
    fetch_en       = fe;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_addr  = ra;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Stream model: issues and accepted words must each walk the address space
  // from the last restart point (reset or redirect), wrapping at 2**AW.
  logic [AW-1:0] exp_pop = RESET_ADDR;
  logic [AW-1:0] exp_issue = RESET_ADDR;
  bit mon_en = 1'b0;
  bit after_flush = 1'b0;
  bit prev_rd_valid = 1'b0;
  bit prev_out_valid = 1'b0;
  int pops = 0;
  int issues = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (after_flush) check_output("empty_after_flush", out_valid, 1'b0);
      if (!rst && out_valid === 1'b1 && !prev_out_valid)
        check_output("head_one_cycle_after_resp", prev_rd_valid, 1'b1);
      after_flush = 1'b0;
      if (rst) begin
        check_output("rd_en_in_reset", ram_rd_en, 1'b0);
        exp_pop     = RESET_ADDR;
        exp_issue   = RESET_ADDR;
        after_flush = 1'b1;
      end else if (redirect_valid) begin
        check_output("rd_en_on_redirect", ram_rd_en, 1'b0);
        exp_pop     = redirect_addr;
        exp_issue   = redirect_addr;
        after_flush = 1'b1;
      end else begin
        if (ram_rd_en === 1'b1) begin
          check_output("issue_addr", ram_rd_addr, exp_issue);
          exp_issue++;
          issues++;
        end
        if (out_valid === 1'b1 && out_ready) begin
          check_output("pop_addr", out_addr, exp_pop);
          check_output("pop_data", out_data, word_of(exp_pop));
          exp_pop++;
          pops++;
        end
      end
      prev_rd_valid  = (ram_rd_valid === 1'b1);
      prev_out_valid = rst ? 1'b0 : (out_valid === 1'b1);
    end
  end

  initial begin
    int p0;
    int i0;
    $display("[TB] fetch_stream bench start");
    mon_en = 1'b1;

    // Reset state and a free-running stream from RESET_ADDR.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 4);
    check_output("reset_out_valid", out_valid, 1'b0);
    check_output("reset_rd_en", ram_rd_en, 1'b0);
    p0 = pops;
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, 20);
    check_output("stream_progress", (pops - p0) >= 10, 1'b1);

    // Consumer stalled: credit stops issue at exactly FIFO_DEPTH words.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 4);
    i0 = issues;
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 20);
    check_output("stall_issue_count", issues - i0, 4);
    check_output("stall_rd_en", ram_rd_en, 1'b0);
    check_output("stall_head_addr", out_addr, 6'h00);
    p0 = pops;
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 8);
    check_output("stall_drain_count", pops - p0, 4);
    check_output("stall_drained_empty", out_valid, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, 10);

    // Redirect with reads in flight: stale responses never surface.
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 6'h20, 1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 8);
    check_output("redir_head_addr", out_addr, 6'h20);
    check_output("redir_head_data", out_data, word_of(6'h20));
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, 6);

    // Redirect near the top of the address space wraps to 0.
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 6'h3E, 1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 8);
    check_output("wrap_head_addr", out_addr, 6'h3E);
    p0 = pops;
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 8);
    check_output("wrap_pop_count", pops - p0, 4);
    check_output("wrap_next_expect", exp_pop, 6'h02);

    // Back-to-back redirects, the first landing on a response cycle.
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, 8);
    check_output("b2b_resp_present", ram_rd_valid, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 6'h10, 1);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 6'h30, 1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 8);
    check_output("b2b_head_addr", out_addr, 6'h30);
    check_output("b2b_head_data", out_data, word_of(6'h30));

    // Reset pulse mid-stream restarts at RESET_ADDR.
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, 8);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, '0, 4);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 8);
    check_output("rst_head_addr", out_addr, RESET_ADDR);
    check_output("rst_head_data", out_data, 32'h0);

    // Random traffic: enable, ready and redirect pulses at random.
    for (int n = 0; n < 400; n++) begin
      apply_stimulus(1'b0, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 6),
                     ($urandom_range(0, 15) == 0), AW'($urandom), 1);
    end
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 12);
    check_output("final_drained", out_valid, 1'b0);
    check_output("final_no_issue", ram_rd_en, 1'b0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
